// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller: one data-memory word transaction per load/store,
// with pipeline stall, load-data capture, timeout abort and misalignment rejection.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_wr_in,
    input  logic        mem_wr_in,
    input  logic [1:0]  res_src_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] wd_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] read_data,
    output logic        bus_err,
    output logic        misalign
);

    localparam logic [1:0]       RES_SRC_LOAD = 2'b01;
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic is_store;
    logic is_load;
    logic pending;
    logic aligned;
    logic unused_reg_wr;

    // The register-write flag travels with the wall but plays no part in the access.
    assign unused_reg_wr = reg_wr_in;

    assign is_store = mem_wr_in;
    assign is_load  = (res_src_in == RES_SRC_LOAD);
    assign pending  = is_store | is_load;
    assign aligned  = (alu_res_in[1:0] == 2'b00);

    // Stall must assert in the detect cycle itself, so it is decoded from state and the wall.
    assign stall = rst_n & ((state == REQ) | ((state == IDLE) & pending & aligned));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            read_data <= '0;
            bus_err   <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            bus_err  <= 1'b0;
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (pending) begin
                        if (aligned) begin
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= alu_res_in;
                            mem_wdata <= wd_in;
                            cnt       <= '0;
                            state     <= REQ;
                        end else begin
                            misalign <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        if (!mem_we) begin
                            read_data <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        // Abort: a timed-out load returns zero; stores leave read_data alone.
                        if (!mem_we) begin
                            read_data <= '0;
                        end
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: randomized wall and memory timing against a transaction-level model.
module tb_mem_stage_ctrl;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 5;

    logic        clk;
    logic        rst_n;
    logic        reg_wr_in;
    logic        mem_wr_in;
    logic [1:0]  res_src_in;
    logic [31:0] alu_res_in;
    logic [31:0] wd_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall;
    logic [31:0] read_data;
    logic        bus_err;
    logic        misalign;

    mem_stage_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reg_wr_in (reg_wr_in),
        .mem_wr_in (mem_wr_in),
        .res_src_in(res_src_in),
        .alu_res_in(alu_res_in),
        .wd_in     (wd_in),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .read_data (read_data),
        .bus_err   (bus_err),
        .misalign  (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outcome of one wall instruction that performs an access.
    typedef struct {
        bit          mis;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          req_cycles;
        bit          to;
    } exp_t;

    // Memory behaviour for one request: ready after w wait cycles, with rdata.
    typedef struct {
        int          w;
        logic [31:0] rdata;
    } rsp_t;

    exp_t        exp_q[$];
    rsp_t        rsp_q[$];
    int          total;
    int          bad;
    logic [31:0] model_rd;
    bit          mon_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Wait until the wall is allowed to advance, then step just past the edge.
    task automatic advance();
        int   n;
        logic st;
        n = 0;
        do begin
            @(negedge clk);
            st = stall;
            n++;
        end while (st === 1'b1 && n < 200);
        if (st === 1'b1) chk("stall_stuck", 32'(st), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Present an instruction in the wall and record what it should produce.
    task automatic present(input bit mw, input logic [1:0] rs, input logic [31:0] addr,
                           input logic [31:0] wd, input int w, input logic [31:0] rdata);
        exp_t e;
        rsp_t r;
        advance();
        reg_wr_in  = 1'($urandom);
        mem_wr_in  = mw;
        res_src_in = rs;
        alu_res_in = addr;
        wd_in      = wd;
        if (!(mw || rs == 2'b01)) return;
        e.mis = 1'b0; e.we = mw; e.addr = addr; e.wdata = wd;
        e.to = 1'b0; e.req_cycles = 0; e.rd = model_rd;
        if (addr[1:0] != 2'b00) begin
            e.mis = 1'b1;
        end else begin
            e.to         = (w >= int'(TIMEOUT));
            e.req_cycles = e.to ? int'(TIMEOUT) : w + 1;
            if (!mw) model_rd = e.to ? 32'd0 : rdata;
            e.rd = model_rd;
            r.w = w;
            r.rdata = rdata;
            rsp_q.push_back(r);
        end
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        present(1'b0, 2'b00, 32'd0, 32'd0, 0, 32'd0);
        n = 0;
        while ((exp_q.size() != 0 || mem_req) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    // Memory responder.
    initial begin
        int   k;
        bit   in_txn;
        rsp_t r;
        k = 0;
        in_txn = 1'b0;
        r.w = 0;
        r.rdata = 32'd0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    k = 0;
                    if (rsp_q.size() > 0) r = rsp_q.pop_front();
                    else begin
                        r.w = 0;
                        r.rdata = 32'hBAD0_BAD0;
                    end
                end else begin
                    k++;
                end
                mem_ready = (k == r.w);
                mem_rdata = (k == r.w) ? r.rdata : $urandom;
            end else begin
                in_txn    = 1'b0;
                mem_ready = 1'($urandom);
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor: pops expectations as the DUT presents requests, completions and pulses.
    initial begin
        bit          prev_req;
        int          req_cnt;
        int          run;
        exp_t        cur;
        exp_t        m;
        logic [31:0] sa;
        logic [31:0] sw;
        bit          swe;
        bit          stable;
        prev_req = 1'b0; req_cnt = 0; run = 0; sa = '0; sw = '0; swe = 1'b0; stable = 1'b1;
        cur.mis = 1'b0; cur.we = 1'b0; cur.addr = '0; cur.wdata = '0; cur.rd = '0;
        cur.req_cycles = 0; cur.to = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                if (mem_req && !prev_req) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_req", 32'd1, 32'd0);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("req_kind", 32'(cur.mis), 32'd0);
                        chk("req_we", 32'(mem_we), 32'(cur.we));
                        chk("req_addr", mem_addr, cur.addr);
                        chk("req_wdata", mem_wdata, cur.wdata);
                    end
                    req_cnt = 1; sa = mem_addr; sw = mem_wdata; swe = mem_we; stable = 1'b1;
                end else if (mem_req) begin
                    req_cnt++;
                    if (mem_addr !== sa || mem_wdata !== sw || mem_we !== swe) stable = 1'b0;
                end else if (prev_req) begin
                    chk("req_len", 32'(req_cnt), 32'(cur.req_cycles));
                    chk("hold_stable", 32'(stable), 32'd1);
                    chk("bus_err", 32'(bus_err), 32'(cur.to));
                    chk("read_data", read_data, cur.rd);
                    chk("done_stall", 32'(stall), 32'd0);
                    chk("stall_len", 32'(run), 32'(cur.req_cycles + 1));
                end else if (bus_err) begin
                    chk("stray_bus_err", 32'(bus_err), 32'd0);
                end
                if (misalign) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_misalign", 32'(misalign), 32'd0);
                    end else begin
                        m = exp_q.pop_front();
                        chk("mis_kind", 32'(m.mis), 32'd1);
                        chk("mis_read_data", read_data, m.rd);
                    end
                end
                if (mem_req && stall !== 1'b1) chk("req_stall", 32'(stall), 32'd1);
            end
            prev_req = mem_req;
            run = (mon_en && stall) ? run + 1 : 0;
        end
    end

    initial begin
        int          n;
        logic [1:0]  rs;
        bit          mw;
        logic [31:0] addr;
        int          w;
        rsp_t        r;
        total = 0; bad = 0; model_rd = 32'd0; mon_en = 1'b1;
        rst_n = 1'b0; reg_wr_in = 1'b0; mem_wr_in = 1'b0; res_src_in = 2'b00;
        alu_res_in = 32'd0; wd_in = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;

        present(1'b0, 2'b01, 32'h0000_0010, 32'h1111_1111, 0, 32'hDEAD_BEEF);
        present(1'b0, 2'b00, 32'h0000_0000, 32'h0, 0, 32'h0);
        present(1'b1, 2'b00, 32'h0000_0020, 32'h1234_5678, 3, 32'h5555_5555);
        present(1'b0, 2'b01, 32'h0000_0030, 32'h0, 100, 32'h7777_7777);
        present(1'b1, 2'b00, 32'h0000_0013, 32'h9999_9999, 0, 32'h0);
        present(1'b0, 2'b01, 32'h0000_0044, 32'h0, 0, 32'hA5A5_A5A5);
        present(1'b1, 2'b01, 32'h0000_0048, 32'hCAFE_0001, 0, 32'h0BAD_0BAD);
        present(1'b0, 2'b01, 32'h0000_004C, 32'h0, int'(TIMEOUT) - 1, 32'h0F0F_0F0F);

        for (int i = 0; i < 300; i++) begin
            mw   = ($urandom_range(0, 2) == 0);
            rs   = 2'($urandom);
            addr = $urandom;
            addr[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            case ($urandom_range(0, 9))
                0:       w = (!mw) ? int'(TIMEOUT) + int'($urandom_range(0, 3)) : 1;
                1:       w = int'(TIMEOUT) - 1;
                default: w = int'($urandom_range(0, 4));
            endcase
            present(mw, rs, addr, $urandom, w, $urandom);
        end
        drain();

        // Reset in the second REQ cycle of a never-answered load.
        mon_en = 1'b0;
        advance();
        mem_wr_in = 1'b0; res_src_in = 2'b01; alu_res_in = 32'h0000_0040;
        r.w = 1000; r.rdata = 32'h0;
        rsp_q.push_back(r);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 20);
        chk("rst_test_req_seen", 32'(mem_req), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req", 32'(mem_req), 32'd0);
        chk("async_rst_stall", 32'(stall), 32'd0);
        chk("async_rst_read_data", read_data, 32'd0);
        res_src_in = 2'b00;
        model_rd = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_mem_req", 32'(mem_req), 32'd0);
            chk("post_rst_stall", 32'(stall), 32'd0);
        end
        mon_en = 1'b1;
        present(1'b0, 2'b01, 32'h0000_0050, 32'h0, 1, 32'hCAFE_F00D);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
